// File: rtl/l2_pmem_pkg.sv
// rtl/l2_pmem_pkg.sv - shared types and helpers for the L2 physical-memory responder
package l2_pmem_pkg;

    localparam int LINE_BITS_DEF = 256;

    // Byte-offset bits inside one line; these address bits never select a line.
    function automatic int offset_bits(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } pmem_state_t;

    typedef logic [LINE_BITS_DEF-1:0] pmem_line_t;

endpackage

// File: rtl/l2_pmem_array.sv
// rtl/l2_pmem_array.sv - line-addressed backing store, sync write, async read, no reset
module l2_pmem_array
    import l2_pmem_pkg::*;
#(
    parameter int LINE_BITS   = LINE_BITS_DEF,
    parameter int DEPTH_LINES = 64,
    parameter int IDX_BITS    = $clog2(DEPTH_LINES)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  idx,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

    // Contents survive reset on purpose: the array models external memory.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule

// File: rtl/l2_pmem_responder.sv
// rtl/l2_pmem_responder.sv - L2 pmem responder with programmable read/write latency
module l2_pmem_responder
    import l2_pmem_pkg::*;
#(
    parameter int LINE_BITS     = LINE_BITS_DEF,
    parameter int ADDR_WIDTH    = 32,
    parameter int DEPTH_LINES   = 64,
    parameter int READ_LATENCY  = 8,
    parameter int WRITE_LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  logic [LINE_BITS-1:0]  pmem_wdata,
    output logic                  pmem_resp,
    output logic [LINE_BITS-1:0]  pmem_rdata,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int OFS     = offset_bits(LINE_BITS);
    localparam int IDX     = $clog2(DEPTH_LINES);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

    pmem_state_t          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_wr_q, op_wr_d;
    logic [IDX-1:0]       idx_q, idx_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 perr_q, perr_d;
    logic [CNT_W-1:0]     load;
    logic [LINE_BITS-1:0] arr_rdata;
    logic                 arr_we;
    logic                 addr_unused;

    // Offset and upper address bits are deliberately dropped: accesses wrap.
    assign addr_unused = ^pmem_address;

    // Transaction FSM: accept in IDLE, count down in WAIT, one-cycle RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        perr_d  = perr_q;
        load    = pmem_write ? WR_LOAD : RD_LOAD;
        case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    // Simultaneous read+write resolves to a write and flags an error.
                    op_wr_d = pmem_write;
                    idx_d   = pmem_address[OFS+IDX-1:OFS];
                    wdata_d = pmem_wdata;
                    perr_d  = perr_q | (pmem_read & pmem_write);
                    cnt_d   = load;
                    state_d = (load == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // Requests still high here belong to this transaction; IDLE re-samples.
                state_d = IDLE;
                if (!op_wr_q) begin
                    rdata_d = arr_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers; async reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Write commits on the edge that ends RESP, so a following read sees it.
    assign arr_we = (state_q == RESP) && op_wr_q;

    l2_pmem_array #(
        .LINE_BITS  (LINE_BITS),
        .DEPTH_LINES(DEPTH_LINES),
        .IDX_BITS   (IDX)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .idx  (idx_q),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    assign pmem_resp  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign proto_err  = perr_q;
    assign pmem_rdata = ((state_q == RESP) && !op_wr_q) ? arr_rdata : rdata_q;

endmodule

// File: tb/tb_l2_pmem_responder.sv
// tb/tb_l2_pmem_responder.sv - randomized self-checking bench for l2_pmem_responder
module tb_l2_pmem_responder;

    typedef logic [255:0] line_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    line_t       wd   [2];

    logic        resp0, resp1, busy0, busy1, perr0, perr1;
    line_t       rdata0, rdata1;
    logic        resp_w  [2];
    logic        busy_w  [2];
    logic        perr_w  [2];
    line_t       rdata_w [2];

    assign resp_w[0]  = resp0;
    assign resp_w[1]  = resp1;
    assign busy_w[0]  = busy0;
    assign busy_w[1]  = busy1;
    assign perr_w[0]  = perr0;
    assign perr_w[1]  = perr1;
    assign rdata_w[0] = rdata0;
    assign rdata_w[1] = rdata1;

    int    n_cmp = 0;
    int    n_bad = 0;
    line_t mdl   [2][64];
    bit    known [2][64];
    int    rd_lat [2] = '{8, 1};
    int    wr_lat [2] = '{8, 3};

    always #5 clk = ~clk;

    l2_pmem_responder u_dut0 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd[0]), .pmem_write(wr[0]),
        .pmem_address(addr[0]), .pmem_wdata(wd[0]), .pmem_resp(resp0),
        .pmem_rdata(rdata0), .busy(busy0), .proto_err(perr0)
    );

    l2_pmem_responder #(.READ_LATENCY(1), .WRITE_LATENCY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pmem_read(rd[1]), .pmem_write(wr[1]),
        .pmem_address(addr[1]), .pmem_wdata(wd[1]), .pmem_resp(resp1),
        .pmem_rdata(rdata1), .busy(busy1), .proto_err(perr1)
    );

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[10:5]);
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction from the current cycle (cycle 0) to the observed resp.
    task automatic run_txn(input int s, input bit w, input bit r, input logic [31:0] a,
                           input line_t d, input int exp_lat, input int exp_busy,
                           input bit scramble, input string nm);
        int    cyc = 0;
        int    bcnt = 0;
        bit    got = 0;
        int    ix = idx_of(a);
        line_t exp_d = mdl[s][ix];
        bit    chk_d = known[s][ix] && !w;
        rd[s] = r; wr[s] = w; addr[s] = a; wd[s] = d;
        while (!got && cyc < 40) begin
            step();
            cyc++;
            if (busy_w[s]) bcnt++;
            if (resp_w[s]) got = 1;
            else if (scramble && cyc == 1) begin
                addr[s] = $urandom;
                wd[s]   = rand_line();
                if ($urandom_range(1, 0) == 1) begin
                    rd[s] = 1'b0; wr[s] = 1'b0;
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s timeout: no resp after %0d cycles, required at %0d", nm, cyc, exp_lat);
        end else begin
            n_cmp++;
            if (cyc !== exp_lat) begin
                n_bad++;
                $display("FAIL %s latency: got %0d required %0d", nm, cyc, exp_lat);
            end
            if (exp_busy >= 0) begin
                n_cmp++;
                if (bcnt !== exp_busy) begin
                    n_bad++;
                    $display("FAIL %s busy cycles: got %0d required %0d", nm, bcnt, exp_busy);
                end
            end
            if (chk_d) begin
                n_cmp++;
                if (rdata_w[s] !== exp_d) begin
                    n_bad++;
                    $display("FAIL %s rdata: got %h required %h", nm, rdata_w[s], exp_d);
                end
            end
        end
        if (w) begin
            mdl[s][ix]   = d;
            known[s][ix] = 1'b1;
        end
        rd[s] = 1'b0; wr[s] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if ({resp_w[s], busy_w[s], perr_w[s]} !== 3'b000 || rdata_w[s] !== '0) begin
                n_bad++;
                $display("FAIL reset dut%0d: resp/busy/err=%b%b%b rdata=%h required 000 and 0",
                         s, resp_w[s], busy_w[s], perr_w[s], rdata_w[s]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        line_t a5 = {32{8'hA5}};
        run_txn(0, 1, 0, 32'h40, a5, 8, 8, 0, "basic_wr");
        step();
        n_cmp++;
        if (resp_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_after_resp: resp=%b busy=%b required 0 0", resp_w[0], busy_w[0]);
        end
        run_txn(0, 0, 1, 32'h40, '0, 8, 8, 0, "basic_rd");
        n_cmp++;
        if (rdata_w[0] !== a5) begin
            n_bad++;
            $display("FAIL basic_rd_value: got %h required %h", rdata_w[0], a5);
        end
    endtask

    task automatic test_eviction();
        step();
        run_txn(0, 1, 0, 32'h80, rand_line(), 8, 8, 0, "evict_wr");
        run_txn(0, 0, 1, 32'h80, '0, 9, 8, 0, "evict_rd");
        n_cmp++;
        if (perr_w[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL evict_proto_err: got %b required 0", perr_w[0]);
        end
    endtask

    task automatic test_wrap();
        line_t p = rand_line();
        step();
        run_txn(0, 1, 0, 32'h0, p, 8, 8, 0, "wrap_wr");
        step();
        run_txn(0, 0, 1, 32'h800, '0, 8, 8, 0, "wrap_rd");
        n_cmp++;
        if (rdata_w[0] !== p) begin
            n_bad++;
            $display("FAIL wrap_value: got %h required %h", rdata_w[0], p);
        end
    endtask

    task automatic test_random(input int s, input int n);
        step();
        for (int i = 0; i < n; i++) begin
            bit    w   = ($urandom_range(1, 0) == 1);
            bit    gap = ($urandom_range(1, 0) == 1);
            int    lat = w ? wr_lat[s] : rd_lat[s];
            logic [31:0] a = $urandom;
            if (!w && $urandom_range(3, 0) != 0) a = {$urandom, 5'h0} | (32'(i % 8) << 5);
            if (gap) step();
            run_txn(s, w, !w, a, rand_line(), gap ? lat : lat + 1, lat, gap, "random");
        end
    endtask

    task automatic test_proto();
        line_t d = rand_line();
        step();
        run_txn(0, 1, 1, 32'h20, d, 8, 8, 0, "proto_both");
        n_cmp++;
        if (perr_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL proto_set: got %b required 1", perr_w[0]);
        end
        step();
        run_txn(0, 0, 1, 32'h20, '0, 8, 8, 0, "proto_rd");
        step();
        run_txn(0, 1, 0, 32'h3A0, rand_line(), 8, 8, 0, "proto_wr2");
        n_cmp++;
        if (perr_w[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL proto_sticky: got %b required 1", perr_w[0]);
        end
    endtask

    task automatic test_reset_mid();
        line_t r = rand_line();
        line_t q = ~r;
        int    resp_seen = 0;
        step();
        run_txn(0, 1, 0, 32'h60, r, 8, 8, 0, "mid_wr_old");
        step();
        wr[0] = 1'b1; addr[0] = 32'h60; wd[0] = q;
        repeat (4) step();
        rst_n = 1'b0;
        wr[0] = 1'b0;
        #1;
        n_cmp++;
        if (busy_w[0] !== 1'b0 || resp_w[0] !== 1'b0 || perr_w[0] !== 1'b0 || rdata_w[0] !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_state: busy=%b resp=%b err=%b rdata=%h required 0 0 0 0",
                     busy_w[0], resp_w[0], perr_w[0], rdata_w[0]);
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) begin
            step();
            if (resp_w[0]) resp_seen++;
        end
        n_cmp++;
        if (resp_seen !== 0) begin
            n_bad++;
            $display("FAIL mid_reset_no_resp: got %0d resp pulses required 0", resp_seen);
        end
        run_txn(0, 0, 1, 32'h60, '0, 8, 8, 0, "mid_rd_old");
    endtask

    task automatic test_lat1();
        line_t da = rand_line();
        line_t db = rand_line();
        line_t exp_d;
        step();
        run_txn(1, 1, 0, 32'h1000_0120, da, 3, 3, 0, "lat1_wr_a");
        step();
        run_txn(1, 1, 0, 32'h2000_03E0, db, 3, 3, 0, "lat1_wr_b");
        step();
        rd[1] = 1'b1; addr[1] = 32'h1000_0120;
        exp_d = da;
        for (int c = 1; c <= 6; c++) begin
            step();
            n_cmp++;
            if (resp_w[1] !== logic'(c % 2)) begin
                n_bad++;
                $display("FAIL lat1_resp_c%0d: got %b required %0d", c, resp_w[1], c % 2);
            end
            if (c % 2 == 1) begin
                if (c == 1) begin
                    addr[1] = 32'h2000_03E0;
                    #1;
                end
                n_cmp++;
                if (rdata_w[1] !== exp_d) begin
                    n_bad++;
                    $display("FAIL lat1_rdata_c%0d: got %h required %h", c, rdata_w[1], exp_d);
                end
                exp_d = db;
            end
        end
        rd[1] = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wd[s] = '0;
            for (int i = 0; i < 64; i++) known[s][i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_eviction();
        test_wrap();
        test_random(0, 16);
        test_random(1, 24);
        test_proto();
        test_reset_mid();
        test_lat1();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
